// File: rtl/vline_gate_if.sv
// rtl/vline_gate_if.sv - control, scan and pixel signals of one vertical wall gate
interface vline_gate_if;
  logic        frame;
  logic        load;
  logic        start;
  logic        freeze;
  logic        flash;
  logic [2:0]  gap_sel;
  logic [15:0] xcoord;
  logic [15:0] ycoord;
  logic        wall_pixel;
  logic        wall_raw;
  logic [15:0] gap_top;
  logic        moving_down;
  logic [7:0]  bounce_cnt;

  modport master (
    output frame, load, start, freeze, flash, gap_sel, xcoord, ycoord,
    input  wall_pixel, wall_raw, gap_top, moving_down, bounce_cnt
  );

  modport slave (
    input  frame, load, start, freeze, flash, gap_sel, xcoord, ycoord,
    output wall_pixel, wall_raw, gap_top, moving_down, bounce_cnt
  );
endinterface

// File: rtl/vline_gate.sv
// rtl/vline_gate.sv - one vertical wall column with a bouncing gap, registered pixel out
module vline_gate #(
  parameter int X_LEFT    = 358,
  parameter int X_RIGHT   = 366,
  parameter int Y_TOP     = 10,
  parameter int Y_BOT     = 470,
  parameter int MARGIN    = 16,
  parameter int GAP_UNIT  = 32,
  parameter int POS_MIN   = 20,
  parameter int POS_MAX   = 440,
  parameter int STEP      = 1,
  parameter int SPEED_DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  vline_gate_if.slave  bus
);

  localparam int DIV_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DOWN = 2'd1;
  localparam logic [1:0] S_UP   = 2'd2;

  logic [1:0]       state;
  logic [15:0]      pos;
  logic [15:0]      gap_len;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       bounce_cnt;
  logic             wall_raw;
  logic             wall_pixel;

  logic             move_tick;
  logic [16:0]      down_sum;
  logic [16:0]      bot_start;
  logic [15:0]      top_lim;
  logic             in_col;
  logic             seg_top;
  logic             seg_bot;
  logic             raw;

  assign move_tick = bus.frame & ~bus.freeze & (div_cnt == DIV_W'(SPEED_DIV - 1));
  assign down_sum  = {1'b0, pos} + 17'(STEP) + {1'b0, gap_len};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      gap_len <= '0;
    end else begin
      if (bus.frame) gap_len <= 16'(bus.gap_sel) * 16'(GAP_UNIT);
      if (bus.frame && !bus.freeze) begin
        if (move_tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Bounce decisions use the gap length in force before this frame's update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pos        <= 16'(POS_MIN);
      bounce_cnt <= '0;
    end else if (bus.load) begin
      state      <= S_IDLE;
      pos        <= 16'(POS_MIN);
      bounce_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) state <= S_DOWN;
        S_DOWN: if (move_tick) begin
          if (down_sum >= 17'(POS_MAX)) begin
            pos   <= 16'(POS_MAX) - gap_len;
            state <= S_UP;
            if (bounce_cnt != 8'hff) bounce_cnt <= bounce_cnt + 8'd1;
          end else begin
            pos <= pos + 16'(STEP);
          end
        end
        S_UP: if (move_tick) begin
          if (pos <= 16'(POS_MIN + STEP)) begin
            pos   <= 16'(POS_MIN);
            state <= S_DOWN;
            if (bounce_cnt != 8'hff) bounce_cnt <= bounce_cnt + 8'd1;
          end else begin
            pos <= pos - 16'(STEP);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Wide sums keep the segment bounds from wrapping near the ends of the range.
  assign top_lim   = pos - 16'(MARGIN);
  assign bot_start = {1'b0, pos} + {1'b0, gap_len};
  assign in_col    = (bus.xcoord >= 16'(X_LEFT)) && (bus.xcoord <= 16'(X_RIGHT));
  assign seg_top   = in_col && (pos >= 16'(MARGIN)) && (bus.ycoord >= 16'(Y_TOP))
                     && (bus.ycoord <= top_lim);
  assign seg_bot   = in_col && ({1'b0, bus.ycoord} >= bot_start)
                     && (bus.ycoord <= 16'(Y_BOT));
  assign raw       = seg_top | seg_bot;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wall_raw   <= 1'b0;
      wall_pixel <= 1'b0;
    end else begin
      wall_raw   <= raw;
      wall_pixel <= raw & (~bus.freeze | bus.flash);
    end
  end

  assign bus.wall_raw    = wall_raw;
  assign bus.wall_pixel  = wall_pixel;
  assign bus.gap_top     = pos - 16'(MARGIN) + 16'd1;
  assign bus.moving_down = (state == S_DOWN);
  assign bus.bounce_cnt  = bounce_cnt;

endmodule

// File: tb/tb_vline_gate.sv
// tb/tb_vline_gate.sv - directed vector bench for vline_gate
module tb_vline_gate;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  vline_gate_if if1 ();
  vline_gate_if if2 ();

  vline_gate u_dut (.clk(clk), .reset(reset), .bus(if1.slave));
  vline_gate #(.SPEED_DIV(4)) u_div (.clk(clk), .reset(reset), .bus(if2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        frz;
    logic        fl;
    logic        exp_raw;
    logic        exp_pix;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    if1.frame = 1'b1;
    tick_clk();
    if1.frame = 1'b0;
    tick_clk();
  endtask

  task automatic pulse_frame2();
    if2.frame = 1'b1;
    tick_clk();
    if2.frame = 1'b0;
    tick_clk();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    // pos=21, gap_len=64: top segment empty (21-16 < Y_TOP), bottom from row 85
    vecs[0]  = '{16'd358, 16'd100, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{16'd366, 16'd100, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{16'd357, 16'd100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'd367, 16'd100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16'd362, 16'd84,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16'd362, 16'd85,  1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{16'd362, 16'd470, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{16'd362, 16'd471, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'd362, 16'd5,   1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'd362, 16'd200, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{16'd362, 16'd200, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{16'd362, 16'd200, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b0;
    if1.frame = 0; if1.load = 0; if1.start = 0; if1.freeze = 0; if1.flash = 0;
    if1.gap_sel = 3'd2; if1.xcoord = 16'd0; if1.ycoord = 16'd0;
    if2.frame = 0; if2.load = 0; if2.start = 0; if2.freeze = 0; if2.flash = 0;
    if2.gap_sel = 3'd2; if2.xcoord = 16'd0; if2.ycoord = 16'd0;
    tick_clk();
    tick_clk();
    check("rst_pixel", 32'(if1.wall_pixel), 0);
    check("rst_raw", 32'(if1.wall_raw), 0);
    check("rst_down", 32'(if1.moving_down), 0);
    check("rst_gap_top", 32'(if1.gap_top), 5);
    check("rst_bounce", 32'(if1.bounce_cnt), 0);

    reset = 1'b1;
    tick_clk();
    if1.load = 1'b1;
    tick_clk();
    if1.load = 1'b0;
    if1.start = 1'b1;
    tick_clk();
    if1.start = 1'b0;
    check("start_down", 32'(if1.moving_down), 1);
    pulse_frame();
    check("first_step", 32'(if1.gap_top), 6);

    for (int i = 0; i < 12; i++) begin
      if1.xcoord = vecs[i].x;
      if1.ycoord = vecs[i].y;
      if1.freeze = vecs[i].frz;
      if1.flash  = vecs[i].fl;
      tick_clk();
      check($sformatf("vec%0d_raw", i), 32'(if1.wall_raw), 32'(vecs[i].exp_raw));
      check($sformatf("vec%0d_pix", i), 32'(if1.wall_pixel), 32'(vecs[i].exp_pix));
    end
    if1.freeze = 1'b0;
    if1.flash  = 1'b0;

    for (int i = 0; i < 354; i++) pulse_frame();
    check("pre_clamp_top", 32'(if1.gap_top), 360);
    check("pre_clamp_dir", 32'(if1.moving_down), 1);
    pulse_frame();
    check("clamp_top", 32'(if1.gap_top), 361);
    check("clamp_dir", 32'(if1.moving_down), 0);
    check("clamp_bounce", 32'(if1.bounce_cnt), 1);
    if1.xcoord = 16'd362;
    if1.ycoord = 16'd439;
    tick_clk();
    check("clamp_row439", 32'(if1.wall_raw), 0);
    if1.ycoord = 16'd440;
    tick_clk();
    check("clamp_row440", 32'(if1.wall_raw), 1);
    pulse_frame();
    check("up_first", 32'(if1.gap_top), 360);

    for (int i = 0; i < 354; i++) pulse_frame();
    check("up_at21", 32'(if1.gap_top), 6);
    check("up_at21_dir", 32'(if1.moving_down), 0);
    pulse_frame();
    check("top_clamp", 32'(if1.gap_top), 5);
    check("top_clamp_dir", 32'(if1.moving_down), 1);
    check("top_bounce", 32'(if1.bounce_cnt), 2);

    for (int i = 0; i < 3; i++) pulse_frame();
    check("after3", 32'(if1.gap_top), 8);
    if1.frame = 1'b1;
    if1.load  = 1'b1;
    tick_clk();
    if1.frame = 1'b0;
    if1.load  = 1'b0;
    tick_clk();
    check("load_pos", 32'(if1.gap_top), 5);
    check("load_idle", 32'(if1.moving_down), 0);
    check("load_bounce", 32'(if1.bounce_cnt), 0);
    pulse_frame();
    check("idle_hold", 32'(if1.gap_top), 5);

    if1.start = 1'b1;
    tick_clk();
    if1.start = 1'b0;
    pulse_frame();
    check("restart", 32'(if1.gap_top), 6);
    if1.freeze = 1'b1;
    for (int i = 0; i < 10; i++) pulse_frame();
    check("freeze_pos", 32'(if1.gap_top), 6);
    check("freeze_dir", 32'(if1.moving_down), 1);
    if1.xcoord = 16'd362;
    if1.ycoord = 16'd200;
    for (int i = 0; i < 4; i++) begin
      if1.flash = (i % 2 == 0);
      tick_clk();
      check($sformatf("flash%0d_pix", i), 32'(if1.wall_pixel), (i % 2 == 0) ? 1 : 0);
      check($sformatf("flash%0d_raw", i), 32'(if1.wall_raw), 1);
    end
    if1.freeze = 1'b0;
    if1.flash  = 1'b0;
    pulse_frame();
    check("unfreeze", 32'(if1.gap_top), 7);

    if2.load = 1'b1;
    tick_clk();
    if2.load = 1'b0;
    if2.start = 1'b1;
    tick_clk();
    if2.start = 1'b0;
    for (int i = 0; i < 3; i++) pulse_frame2();
    check("div_3", 32'(if2.gap_top), 5);
    pulse_frame2();
    check("div_4", 32'(if2.gap_top), 6);
    for (int i = 0; i < 3; i++) pulse_frame2();
    check("div_7", 32'(if2.gap_top), 6);
    pulse_frame2();
    check("div_8", 32'(if2.gap_top), 7);
    if2.xcoord  = 16'd362;
    if2.gap_sel = 3'd4;
    if2.ycoord  = 16'd86;
    tick_clk();
    check("midframe_86", 32'(if2.wall_raw), 1);
    if2.ycoord = 16'd85;
    tick_clk();
    check("midframe_85", 32'(if2.wall_raw), 0);
    pulse_frame2();
    check("div_9_hold", 32'(if2.gap_top), 7);
    if2.ycoord = 16'd149;
    tick_clk();
    check("newgap_149", 32'(if2.wall_raw), 0);
    if2.ycoord = 16'd150;
    tick_clk();
    check("newgap_150", 32'(if2.wall_raw), 1);
    if2.ycoord = 16'd86;
    tick_clk();
    check("newgap_86", 32'(if2.wall_raw), 0);

    if1.xcoord = 16'd362;
    if1.ycoord = 16'd200;
    tick_clk();
    check("pre_rst_raw", 32'(if1.wall_raw), 1);
    #3;
    reset = 1'b0;
    #1;
    check("async_raw", 32'(if1.wall_raw), 0);
    check("async_pix", 32'(if1.wall_pixel), 0);
    check("async_dir", 32'(if1.moving_down), 0);
    check("async_top", 32'(if1.gap_top), 5);
    check("async_div_dir", 32'(if2.moving_down), 0);
    tick_clk();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) tick_clk();
    check("post_rst_idle", 32'(if1.moving_down), 0);
    check("post_rst_top", 32'(if1.gap_top), 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vline_gate.md
Name: vline_gate

Overview:
Parametrised successor of the fixed per-column vertical wall generators. It draws one vertical wall column with a moving gap, with column position, wall thickness, gap size and motion range all set by parameters. It contains its own bounce FSM, frame-rate divider and bounce counter, and registers the pixel output. Scan coordinates come from the shared pixel counters, so each instance no longer carries private counters; one instance is placed per obstacle column and its outputs are OR-ed into the colour mux.

Parameters:
X_LEFT, 358, leftmost wall pixel column (inclusive)
X_RIGHT, 366, rightmost wall pixel column (inclusive)
Y_TOP, 10, first drawable wall row (inclusive)
Y_BOT, 470, last drawable wall row (inclusive)
MARGIN, 16, rows of gap above pos; gap starts at pos-MARGIN+1
GAP_UNIT, 32, gap extension below pos per gap_sel count
POS_MIN, 20, upper turn-around limit and load value of pos
POS_MAX, 440, lower turn-around limit for pos+gap_len
STEP, 1, rows moved per move tick
SPEED_DIV, 1, frame pulses per move tick (>=1)

Ports:
clk  in  1  system pixel clock
reset  in  1  asynchronous, active-low reset
frame  in  1  one-clk pulse at start of vertical blank
load  in  1  synchronous; pos<=POS_MIN, FSM->IDLE, bounce_cnt<=0
start  in  1  level; leaves IDLE toward DOWN
freeze  in  1  1 = motion halted, wall drawn only while flash=1
flash  in  1  blink enable from the shared flash timer
gap_sel  in  3  gap length = gap_sel*GAP_UNIT (below pos)
xcoord  in  16  current scan column
ycoord  in  16  current scan row
wall_pixel  out  1  registered, freeze/flash-gated wall pixel
wall_raw  out  1  registered, ungated wall pixel (collision use)
gap_top  out  16  pos-MARGIN+1, the first row of the open gap
moving_down  out  1  1 in DOWN state
bounce_cnt  out  8  turn-arounds since load, saturates at 255

Behaviour:
- Reset (reset=0, async): pos=POS_MIN, state IDLE, div_cnt=0, gap_len=0, bounce_cnt=0. wall_pixel=0, wall_raw=0, moving_down=0, gap_top=POS_MIN-MARGIN+1.
- gap_len register: on each frame pulse, gap_len<=gap_sel*GAP_UNIT, zero-extended to 16 bits. Gap size therefore never changes mid-frame.
- Move tick: generated on a frame pulse when freeze=0 and div_cnt==SPEED_DIV-1. div_cnt then clears; otherwise div_cnt increments on frame pulses while freeze=0. freeze=1 holds div_cnt.
- FSM states: IDLE, DOWN, UP. All transitions happen only on a move tick, except IDLE->DOWN.
  - IDLE: start=1 -> DOWN on the next clk. pos holds.
  - DOWN, on tick: if pos+STEP+gap_len >= POS_MAX, then pos<=POS_MAX-gap_len (clamp), ->UP, bounce_cnt++. Else pos<=pos+STEP.
  - UP, on tick: if pos <= POS_MIN+STEP, then pos<=POS_MIN (clamp), ->DOWN, bounce_cnt++. Else pos<=pos-STEP.
  - start=0 does not stop a moving gate. Only load returns it to IDLE.
- Priority: reset > load > move tick. If load and tick fall in the same clk, load wins and no step occurs.
- gap_len growth: if gap_len grows while in DOWN so that pos+gap_len > POS_MAX, the next tick clamps and reverses. No out-of-range state persists.
- Pixel decode (combinational, then registered, 1 clk latency):
  - in_col = X_LEFT <= xcoord <= X_RIGHT.
  - seg_top = in_col & ycoord >= Y_TOP & ycoord <= pos-MARGIN.
  - seg_bot = in_col & ycoord >= pos+gap_len & ycoord <= Y_BOT.
  - raw = seg_top | seg_bot. wall_raw <= raw.
  - wall_pixel <= raw & (~freeze | flash).
- Arithmetic is 16-bit unsigned. If pos < MARGIN, seg_top is empty (no wrap). If pos+gap_len > Y_BOT, seg_bot is empty.
- gap_top and moving_down are combinational from registers. bounce_cnt holds at 255.

Test Plan:
- Reset, release, load, then start with gap_sel=2 and SPEED_DIV=1 -> the first frame pulse moves pos 20->21. At row 100, wall_raw=1 for xcoord 358..366 and 0 at 357/367, one clk after the coordinates are presented.
- Run DOWN with gap_sel=2 (gap_len=64) -> pos clamps at 376, state goes UP, bounce_cnt=1. The next tick gives pos=375.
- UP reaches pos 21, then a tick gives pos=20, DOWN, bounce_cnt=2. Assert load together with a frame pulse -> pos=20, IDLE, bounce_cnt=0, no step.
- freeze=1 for 10 frames -> pos unchanged. With flash toggling, wall_pixel follows flash while wall_raw stays set. Release freeze -> motion resumes on the next frame pulse.
- SPEED_DIV=4 -> pos steps once per 4 frame pulses. Change gap_sel mid-frame -> seg_bot boundary changes only after the next frame pulse.
- Assert reset low mid-DOWN between clock edges -> outputs clear immediately (no clk edge needed), and the FSM is in IDLE after release.
